// File: rtl/mlp_pkg.sv
// Shared types and sizing for the MLP classifier front end.
// Quantization mode is selected in mlp_feat_quant by the QUANT_ROUND_EN macro.
package mlp_pkg;

    localparam int N_FEAT  = 9;
    localparam int IN_W    = 8;
    localparam int Q_W     = 4;
    localparam int Q_SHIFT = 4;
    localparam int CNT_W   = 16;

    localparam int VEC_W = N_FEAT * Q_W;
    localparam int IDX_W = $clog2(N_FEAT);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/mlp_feat_quant.sv
// Combinational raw-feature quantizer: shift down, then saturate to Q_W bits.
// Define QUANT_ROUND_EN for round-half-up; otherwise the shift truncates.
module mlp_feat_quant
    import mlp_pkg::*;
(
    input  logic [IN_W-1:0] raw,
    output logic [Q_W-1:0]  q
);

    localparam logic [IN_W:0]  Q_MAX_WIDE = (IN_W+1)'((1 << Q_W) - 1);
    localparam logic [Q_W-1:0] Q_SAT      = '1;

    logic [IN_W:0] shifted;

`ifdef QUANT_ROUND_EN
    // One extra bit of headroom so adding the half-step cannot wrap.
    localparam logic [IN_W:0] HALF = (IN_W+1)'(1 << (Q_SHIFT - 1));
    logic [IN_W:0] sum;

    assign sum     = {1'b0, raw} + HALF;
    assign shifted = sum >> Q_SHIFT;
`else
    assign shifted = {1'b0, raw} >> Q_SHIFT;
`endif

    always_comb begin
        if (shifted > Q_MAX_WIDE) begin
            q = Q_SAT;
        end else begin
            q = shifted[Q_W-1:0];
        end
    end

endmodule

// File: rtl/mlp_feature_loader.sv
// Collects N_FEAT quantized features into a packed vector and holds it until the
// classifier accepts it. Quantization rounding is enabled by QUANT_ROUND_EN.
module mlp_feature_loader
    import mlp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             feat_valid_i,
    output logic             feat_ready_o,
    input  logic [IN_W-1:0]  feat_data_i,
    input  logic             feat_last_i,
    input  logic             clear_i,
    output logic             vec_valid_o,
    input  logic             vec_ready_i,
    output logic [VEC_W-1:0] vec_o,
    output logic             err_o,
    output logic [CNT_W-1:0] frame_cnt_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [Q_W-1:0]   q_beat;
    logic             accept;
    logic             handshake;

    mlp_feat_quant u_quant (
        .raw (feat_data_i),
        .q   (q_beat)
    );

    // feat_ready_o is only high in COLLECT, so acceptance implies COLLECT.
    assign accept    = feat_valid_i & feat_ready_o;
    assign handshake = vec_valid_o & vec_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= COLLECT;
            idx          <= '0;
            feat_ready_o <= 1'b1;
            vec_valid_o  <= 1'b0;
            vec_o        <= '0;
            err_o        <= 1'b0;
            frame_cnt_o  <= '0;
        end else begin
            err_o <= 1'b0;

            // A handshake coinciding with clear_i still counts as delivered.
            if (handshake) begin
                frame_cnt_o <= frame_cnt_o + 1'b1;
            end

            if (clear_i) begin
                state        <= COLLECT;
                idx          <= '0;
                feat_ready_o <= 1'b1;
                vec_valid_o  <= 1'b0;
            end else begin
                case (state)
                    COLLECT: begin
                        if (accept) begin
                            for (int k = 0; k < N_FEAT; k++) begin
                                if (idx == IDX_W'(k)) begin
                                    vec_o[k*Q_W +: Q_W] <= q_beat;
                                end
                            end

                            if (feat_last_i) begin
                                idx <= '0;
                                if (idx == LAST_IDX) begin
                                    state        <= HOLD;
                                    vec_valid_o  <= 1'b1;
                                    feat_ready_o <= 1'b0;
                                end else begin
                                    err_o <= 1'b1;
                                end
                            end else if (idx == LAST_IDX) begin
                                // Over-long frame: drop it and start counting afresh.
                                idx   <= '0;
                                err_o <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end

                    HOLD: begin
                        if (handshake) begin
                            state        <= COLLECT;
                            vec_valid_o  <= 1'b0;
                            feat_ready_o <= 1'b1;
                        end
                    end

                    default: begin
                        state <= COLLECT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mlp_feature_loader.sv
// Self-checking bench for mlp_feature_loader: directed scenarios plus randomized
// traffic against a frame-level reference model. Honors QUANT_ROUND_EN.
module tb_mlp_feature_loader;
    import mlp_pkg::*;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             feat_valid = 1'b0;
    logic [IN_W-1:0]  feat_data  = '0;
    logic             feat_last  = 1'b0;
    logic             clear      = 1'b0;
    logic             vec_ready  = 1'b1;
    logic             feat_ready;
    logic             vec_valid;
    logic [VEC_W-1:0] vec;
    logic             err;
    logic [CNT_W-1:0] frame_cnt;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: position within frame, held flag, slot contents, counters.
    bit m_hold = 1'b0;
    bit m_err  = 1'b0;
    int m_pos  = 0;
    int m_cnt  = 0;
    int m_slot [N_FEAT];

    always #5 clk = ~clk;

    mlp_feature_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .feat_valid_i (feat_valid),
        .feat_ready_o (feat_ready),
        .feat_data_i  (feat_data),
        .feat_last_i  (feat_last),
        .clear_i      (clear),
        .vec_valid_o  (vec_valid),
        .vec_ready_i  (vec_ready),
        .vec_o        (vec),
        .err_o        (err),
        .frame_cnt_o  (frame_cnt)
    );

    function automatic int q_ref(input int d);
        int v;
`ifdef QUANT_ROUND_EN
        v = (d + (1 << (Q_SHIFT - 1))) / (1 << Q_SHIFT);
`else
        v = d / (1 << Q_SHIFT);
`endif
        return (v > (1 << Q_W) - 1) ? (1 << Q_W) - 1 : v;
    endfunction

    function automatic logic [VEC_W-1:0] m_vec();
        logic [VEC_W-1:0] v;
        v = '0;
        for (int k = 0; k < N_FEAT; k++) v[k*Q_W +: Q_W] = Q_W'(m_slot[k]);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Model advances on each clock edge from the inputs seen at that edge.
    initial begin
        foreach (m_slot[k]) m_slot[k] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_hold = 1'b0;
                m_err  = 1'b0;
                m_pos  = 0;
                m_cnt  = 0;
                foreach (m_slot[k]) m_slot[k] = 0;
            end else begin
                bit hs;
                bit new_err;
                hs      = m_hold && vec_ready;
                new_err = 1'b0;
                if (hs) m_cnt = (m_cnt + 1) % (1 << CNT_W);
                if (clear) begin
                    m_hold = 1'b0;
                    m_pos  = 0;
                end else if (m_hold) begin
                    if (hs) m_hold = 1'b0;
                end else if (feat_valid) begin
                    m_slot[m_pos] = q_ref(int'(feat_data));
                    if (feat_last) begin
                        if (m_pos == N_FEAT - 1) m_hold = 1'b1;
                        else new_err = 1'b1;
                        m_pos = 0;
                    end else if (m_pos == N_FEAT - 1) begin
                        new_err = 1'b1;
                        m_pos   = 0;
                    end else begin
                        m_pos++;
                    end
                end
                m_err = new_err;
            end
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("feat_ready", feat_ready, !m_hold);
            check("vec_valid", vec_valid, m_hold);
            check("err", err, m_err);
            check("frame_cnt", frame_cnt, m_cnt);
            if (m_hold) check("vec", vec, m_vec());
        end
    end

    task automatic send_beat(input logic [IN_W-1:0] d, input logic last);
        int waited;
        waited     = 0;
        feat_valid = 1'b1;
        feat_data  = d;
        feat_last  = last;
        while (!feat_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!feat_ready) begin
            n_total++;
            $display("[TB] FAIL beat_timeout: feat_ready=%0b, required 1", feat_ready);
        end
        @(negedge clk);
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    task automatic send_nominal();
        for (int k = 0; k < N_FEAT; k++) send_beat(IN_W'((k + 1) * 16), k == N_FEAT - 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_feat_ready"}, feat_ready, 1);
        check({tag, "_vec_valid"}, vec_valid, 0);
        check({tag, "_vec"}, vec, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal frame: nibble k holds k+1.
        send_nominal();
        check("nominal_valid", vec_valid, 1);
        check("nominal_vec", vec, 36'h987654321);
        @(negedge clk);
        check("nominal_cnt", frame_cnt, 1);
        check("nominal_released", vec_valid, 0);

        // Saturating frame under sustained backpressure.
        vec_ready = 1'b0;
        for (int k = 0; k < N_FEAT; k++) send_beat(8'hFA, k == N_FEAT - 1);
        for (int c = 0; c < 20; c++) begin
            check("bp_valid", vec_valid, 1);
            check("bp_ready", feat_ready, 0);
            check("bp_vec", vec, 36'hFFFFFFFFF);
            @(negedge clk);
        end
        vec_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", vec_valid, 0);
        check("bp_release_ready", feat_ready, 1);
        check("bp_cnt", frame_cnt, 2);

        // Rounding boundary: 0x17 and 0x18.
        send_beat(8'h17, 1'b0);
        send_beat(8'h18, 1'b0);
        for (int k = 2; k < N_FEAT; k++) send_beat(8'h00, k == N_FEAT - 1);
`ifdef QUANT_ROUND_EN
        check("round_vec", vec, 36'h000000021);
`else
        check("trunc_vec", vec, 36'h000000011);
`endif
        @(negedge clk);
        check("round_cnt", frame_cnt, 3);

        // Short frame: last on the fifth beat.
        for (int k = 0; k < 5; k++) send_beat(8'h33, k == 4);
        check("short_err", err, 1);
        check("short_valid", vec_valid, 0);
        @(negedge clk);
        check("short_err_pulse", err, 0);
        send_nominal();
        check("after_short_vec", vec, 36'h987654321);
        @(negedge clk);
        check("after_short_cnt", frame_cnt, 4);

        // Long frame: ninth beat without last, then the next beat lands in slot 0.
        for (int k = 0; k < N_FEAT; k++) send_beat(8'h50, 1'b0);
        check("long_err", err, 1);
        check("long_valid", vec_valid, 0);
        send_beat(8'hA0, 1'b0);
        for (int k = 1; k < N_FEAT; k++) send_beat(IN_W'((k + 1) * 16), k == N_FEAT - 1);
        check("after_long_vec", vec, 36'h98765432A);
        @(negedge clk);
        check("after_long_cnt", frame_cnt, 5);

        // Clear after four beats, with a colliding beat that must be dropped.
        for (int k = 0; k < 4; k++) send_beat(8'h70, 1'b0);
        feat_valid = 1'b1;
        feat_data  = 8'hE0;
        clear      = 1'b1;
        @(negedge clk);
        clear      = 1'b0;
        feat_valid = 1'b0;
        check("clear_err", err, 0);
        check("clear_ready", feat_ready, 1);
        send_nominal();
        check("after_clear_vec", vec, 36'h987654321);
        @(negedge clk);
        check("after_clear_cnt", frame_cnt, 6);

        // Clear coinciding with a vector handshake.
        vec_ready = 1'b0;
        send_nominal();
        repeat (3) @(negedge clk);
        vec_ready = 1'b1;
        clear     = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_hs_cnt", frame_cnt, 7);
        check("clear_hs_valid", vec_valid, 0);

        // Asynchronous reset while holding a vector.
        vec_ready = 1'b0;
        send_nominal();
        check("pre_reset_valid", vec_valid, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        rst_n     = 1'b1;
        vec_ready = 1'b1;
        @(negedge clk);

        // Randomized traffic, biased so many frames terminate on the right beat.
        for (int c = 0; c < 3000; c++) begin
            feat_valid = $urandom_range(0, 3) != 0;
            feat_data  = IN_W'($urandom);
            feat_last  = (m_pos == N_FEAT - 1) ? ($urandom_range(0, 9) < 8)
                                               : ($urandom_range(0, 29) == 0);
            clear      = $urandom_range(0, 49) == 0;
            vec_ready  = $urandom_range(0, 9) < 7;
            @(negedge clk);
        end
        feat_valid = 1'b0;
        feat_last  = 1'b0;
        clear      = 1'b0;
        vec_ready  = 1'b1;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
